frame_buffer_requester: RTL



---
 rtl/frame_buffer_requester.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_requester.sv
// frame_buffer_requester: client-side lease manager for the triple-buffer controller.
// Requests a buffer id, converts it to an SDRAM base address, tracks the word
// address through the frame and releases the buffer with a finalize pulse.
// Optional feature macro: REQ_TIMEOUT_EN (grant-wait timeout detection).
module frame_buffer_requester #(
    parameter int unsigned ADDR_WIDTH     = 21,
    parameter int unsigned FRAME_WORDS    = 76800,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  word_strobe,
    output logic                  rq_rdy,
    output logic                  finalize,
    input  logic                  buffer_id_valid,
    input  logic [1:0]            buffer_id,
    output logic                  lease_active,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic                  dropped_frame,
    output logic                  overflow,
    output logic                  grant_err,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] FRAME_WORDS_A = ADDR_WIDTH'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CNT_W-1:0]      CNT_FULL      = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  abort_pending;
    logic                  abort_nxt;
    logic [CNT_W-1:0]      word_cnt;
    logic [CNT_W-1:0]      word_cnt_nxt;
    logic [ADDR_WIDTH-1:0] base_nxt;
    logic [ADDR_WIDTH-1:0] word_addr_nxt;
    logic                  dropped_nxt;
    logic                  overflow_nxt;
    logic                  grant_err_nxt;
    logic [ADDR_WIDTH-1:0] grant_base_c;

    // Base address of the granted buffer, computed at address width
    assign grant_base_c = BASE_ADDR_A + ADDR_WIDTH'(buffer_id) * FRAME_WORDS_A;

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        abort_nxt     = abort_pending;
        word_cnt_nxt  = word_cnt;
        base_nxt      = base_addr;
        word_addr_nxt = word_addr;
        dropped_nxt   = 1'b0;
        overflow_nxt  = overflow;
        grant_err_nxt = grant_err;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                if (frame_end) begin
                    abort_nxt   = 1'b1;
                    dropped_nxt = 1'b1;
                end
                if (buffer_id_valid) begin
                    if (buffer_id == 2'd3) begin
                        grant_err_nxt = 1'b1;
                        state_nxt     = RELEASE;
                    end else begin
                        base_nxt      = grant_base_c;
                        word_addr_nxt = grant_base_c;
                        word_cnt_nxt  = '0;
                        state_nxt     = (abort_pending || frame_end) ? RELEASE : ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (word_strobe) begin
                    if (word_cnt == CNT_FULL) begin
                        overflow_nxt = 1'b1;
                    end else begin
                        word_cnt_nxt = word_cnt + CNT_W'(1);
                        // Address stops at the last word of the buffer
                        if (word_cnt < CNT_LAST) begin
                            word_addr_nxt = word_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                if (frame_end) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                abort_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            abort_pending <= 1'b0;
            word_cnt      <= '0;
            rq_rdy        <= 1'b0;
            finalize      <= 1'b0;
            lease_active  <= 1'b0;
            base_addr     <= '0;
            word_addr     <= '0;
            dropped_frame <= 1'b0;
            overflow      <= 1'b0;
            grant_err     <= 1'b0;
        end else begin
            state         <= state_nxt;
            abort_pending <= abort_nxt;
            word_cnt      <= word_cnt_nxt;
            rq_rdy        <= (state_nxt == REQUEST);
            finalize      <= (state_nxt == RELEASE);
            lease_active  <= (state_nxt == ACTIVE);
            base_addr     <= base_nxt;
            word_addr     <= word_addr_nxt;
            dropped_frame <= dropped_nxt;
            overflow      <= overflow_nxt;
            grant_err     <= grant_err_nxt;
        end
    end

`ifdef REQ_TIMEOUT_EN
    localparam int unsigned       WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout_err_nxt;

    // Grant-wait counter: saturates at the limit, cleared outside REQUEST
    always_comb begin
        wait_cnt_nxt    = wait_cnt;
        timeout_err_nxt = timeout_err;
        if (state == REQUEST) begin
            if (wait_cnt == WAIT_LIMIT) begin
                timeout_err_nxt = 1'b1;
            end else begin
                wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
        end
        if (state_nxt != REQUEST) begin
            wait_cnt_nxt = '0;
        end
    end

    // Wait counter and sticky timeout flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end
`else
    // Timeout detection not built; the parameter stays on the interface
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

endmodule
